// File: rtl/vga_sync_gen.sv
// vga_sync_gen: VGA raster timing generator with registered sync, blank and colour outputs.
// Horizontal and vertical counters walk the full raster.
// Every registered output is derived from the same counter state,
// so hsync_n, vsync_n, blank_n, frame_tick and the colour channels stay aligned.
// Optional build macro VGA_TEST_PATTERN_EN: replaces the external colour inputs
// with an internal eight-bar colour pattern in the visible area.

module vga_sync_gen #(
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33
) (
    input  logic       pixel_clck,
    input  logic       reset,
    input  logic [3:0] red_in,
    input  logic [3:0] green_in,
    input  logic [3:0] blue_in,
    output logic [9:0] x_coords,
    output logic [9:0] y_coords,
    output logic [3:0] vga_r,
    output logic [3:0] vga_g,
    output logic [3:0] vga_b,
    output logic       hsync_n,
    output logic       vsync_n,
    output logic       blank_n,
    output logic       frame_tick
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    // All counter boundaries as 10-bit unsigned constants
    localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS_END  = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS_END  = 10'(V_VISIBLE);
    localparam logic [9:0] HS_START   = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] HS_END     = 10'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [9:0] VS_START   = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] VS_END     = 10'(V_VISIBLE + V_FRONT + V_SYNC);

    logic [9:0] h_count_q, h_count_d;
    logic [9:0] v_count_q, v_count_d;
    logic [3:0] vga_r_q, vga_r_d;
    logic [3:0] vga_g_q, vga_g_d;
    logic [3:0] vga_b_q, vga_b_d;
    logic       hsync_n_q, hsync_n_d;
    logic       vsync_n_q, vsync_n_d;
    logic       blank_n_q, blank_n_d;
    logic       frame_tick_q, frame_tick_d;

    logic       visible;
    logic       hsync_active;
    logic       vsync_active;
    logic [3:0] src_r, src_g, src_b;

`ifdef VGA_TEST_PATTERN_EN
    localparam logic [9:0] BAR_W = 10'(H_VISIBLE / 8);

    logic [9:0] bar_idx;
    logic       unused_colour_in;

    assign unused_colour_in = ^{red_in, green_in, blue_in};

    // Eight vertical bars: white, yellow, cyan, green, magenta, red, blue, black
    always_comb begin
        bar_idx = h_count_q / BAR_W;
        src_r   = 4'h0;
        src_g   = 4'h0;
        src_b   = 4'h0;
        case (bar_idx)
            10'd0: begin src_r = 4'hF; src_g = 4'hF; src_b = 4'hF; end
            10'd1: begin src_r = 4'hF; src_g = 4'hF; end
            10'd2: begin src_g = 4'hF; src_b = 4'hF; end
            10'd3: begin src_g = 4'hF; end
            10'd4: begin src_r = 4'hF; src_b = 4'hF; end
            10'd5: begin src_r = 4'hF; end
            10'd6: begin src_b = 4'hF; end
            default: ;
        endcase
    end
`else
    // Colour comes straight from the external pixel generator
    always_comb begin
        src_r = red_in;
        src_g = green_in;
        src_b = blue_in;
    end
`endif

    // Next counter state and the registered-output values for the current raster position
    always_comb begin
        h_count_d = h_count_q + 10'd1;
        v_count_d = v_count_q;
        if (h_count_q == H_LAST) begin
            h_count_d = 10'd0;
            v_count_d = (v_count_q == V_LAST) ? 10'd0 : v_count_q + 10'd1;
        end

        visible      = (h_count_q < H_VIS_END) && (v_count_q < V_VIS_END);
        hsync_active = (h_count_q >= HS_START) && (h_count_q < HS_END);
        vsync_active = (v_count_q >= VS_START) && (v_count_q < VS_END);

        hsync_n_d    = ~hsync_active;
        vsync_n_d    = ~vsync_active;
        blank_n_d    = visible;
        frame_tick_d = (h_count_q == 10'd0) && (v_count_q == 10'd0);
        vga_r_d      = visible ? src_r : 4'h0;
        vga_g_d      = visible ? src_g : 4'h0;
        vga_b_d      = visible ? src_b : 4'h0;
    end

    // Counters and outputs advance together; reset parks everything at the raster origin
    always_ff @(posedge pixel_clck) begin
        if (reset) begin
            h_count_q    <= 10'd0;
            v_count_q    <= 10'd0;
            vga_r_q      <= 4'h0;
            vga_g_q      <= 4'h0;
            vga_b_q      <= 4'h0;
            hsync_n_q    <= 1'b1;
            vsync_n_q    <= 1'b1;
            blank_n_q    <= 1'b0;
            frame_tick_q <= 1'b0;
        end else begin
            h_count_q    <= h_count_d;
            v_count_q    <= v_count_d;
            vga_r_q      <= vga_r_d;
            vga_g_q      <= vga_g_d;
            vga_b_q      <= vga_b_d;
            hsync_n_q    <= hsync_n_d;
            vsync_n_q    <= vsync_n_d;
            blank_n_q    <= blank_n_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign x_coords   = h_count_q;
    assign y_coords   = v_count_q;
    assign vga_r      = vga_r_q;
    assign vga_g      = vga_g_q;
    assign vga_b      = vga_b_q;
    assign hsync_n    = hsync_n_q;
    assign vsync_n    = vsync_n_q;
    assign blank_n    = blank_n_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// tb_vga_sync_gen: scoreboard bench for vga_sync_gen.
// Horizontal timing is the standard 800-pixel line; vertical timing is
// shrunk to 13 lines (6 visible, front 2, sync 2, back 3) so whole frames are short.

module tb_vga_sync_gen;

    logic       pixel_clck = 1'b0;
    logic       reset      = 1'b1;
    logic [3:0] red_in     = 4'h0;
    logic [3:0] green_in   = 4'h0;
    logic [3:0] blue_in    = 4'h0;
    logic [9:0] x_coords;
    logic [9:0] y_coords;
    logic [3:0] vga_r;
    logic [3:0] vga_g;
    logic [3:0] vga_b;
    logic       hsync_n;
    logic       vsync_n;
    logic       blank_n;
    logic       frame_tick;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
        logic       hs;
        logic       vs;
        logic       bl;
        logic       tk;
        logic       win;
    } exp_t;

    exp_t expQueue[$];

    int total = 0;
    int bad   = 0;
    int cycleNo = 0;

    int modelH = 0;
    int modelV = 0;

    int hsLow   = 0;
    int vsLow   = 0;
    int tickCnt = 0;
    int blankHi = 0;
    int redHit  = 0;

    vga_sync_gen #(
        .H_VISIBLE(640), .H_FRONT(16), .H_SYNC(96), .H_BACK(48),
        .V_VISIBLE(6),   .V_FRONT(2),  .V_SYNC(2),  .V_BACK(3)
    ) dut (
        .pixel_clck(pixel_clck),
        .reset(reset),
        .red_in(red_in),
        .green_in(green_in),
        .blue_in(blue_in),
        .x_coords(x_coords),
        .y_coords(y_coords),
        .vga_r(vga_r),
        .vga_g(vga_g),
        .vga_b(vga_b),
        .hsync_n(hsync_n),
        .vsync_n(vsync_n),
        .blank_n(blank_n),
        .frame_tick(frame_tick)
    );

    always #5 pixel_clck = ~pixel_clck;

    // Eight-bar pattern colour for a horizontal position: {r,g,b}
    function automatic logic [11:0] patternColour(input int h);
        case (h / 80)
            0: return 12'hFFF;
            1: return 12'hFF0;
            2: return 12'h0FF;
            3: return 12'h0F0;
            4: return 12'hF0F;
            5: return 12'hF00;
            6: return 12'h00F;
            default: return 12'h000;
        endcase
    endfunction

    // Drive one cycle of inputs and queue the response expected after the next edge
    task automatic applyStimulus(input logic rst, input logic [3:0] r, input logic [3:0] g,
                                 input logic [3:0] b, input logic win);
        exp_t e;
        logic vis;
        logic [11:0] col;
        @(negedge pixel_clck);
        reset    = rst;
        red_in   = r;
        green_in = g;
        blue_in  = b;
        e.win = win;
        if (rst) begin
            e.r = 4'h0; e.g = 4'h0; e.b = 4'h0;
            e.hs = 1'b1; e.vs = 1'b1; e.bl = 1'b0; e.tk = 1'b0;
            modelH = 0;
            modelV = 0;
        end else begin
            vis  = (modelH < 640) && (modelV < 6);
`ifdef VGA_TEST_PATTERN_EN
            col  = patternColour(modelH);
`else
            col  = {r, g, b};
`endif
            e.r  = vis ? col[11:8] : 4'h0;
            e.g  = vis ? col[7:4]  : 4'h0;
            e.b  = vis ? col[3:0]  : 4'h0;
            e.hs = !((modelH >= 656) && (modelH < 752));
            e.vs = !((modelV >= 8) && (modelV < 10));
            e.bl = vis;
            e.tk = (modelH == 0) && (modelV == 0);
            if (modelH == 799) begin
                modelH = 0;
                modelV = (modelV == 12) ? 0 : modelV + 1;
            end else begin
                modelH = modelH + 1;
            end
        end
        e.x = 10'(modelH);
        e.y = 10'(modelV);
        expQueue.push_back(e);
    endtask

    // Pop one expected response and compare it with what the DUT shows
    task automatic checkOutput();
        exp_t e;
        logic [37:0] act, req;
        e = expQueue.pop_front();
        cycleNo++;
        act = {x_coords, y_coords, vga_r, vga_g, vga_b, hsync_n, vsync_n, blank_n, frame_tick};
        req = {e.x, e.y, e.r, e.g, e.b, e.hs, e.vs, e.bl, e.tk};
        total++;
        if (act !== req) begin
            bad++;
            $display("[TB] FAIL cycle%0d got x=%0d y=%0d rgb=%h%h%h hs=%b vs=%b bl=%b tk=%b required x=%0d y=%0d rgb=%h%h%h hs=%b vs=%b bl=%b tk=%b",
                     cycleNo, x_coords, y_coords, vga_r, vga_g, vga_b, hsync_n, vsync_n, blank_n, frame_tick,
                     e.x, e.y, e.r, e.g, e.b, e.hs, e.vs, e.bl, e.tk);
        end
        if (e.win) begin
            if (!hsync_n)      hsLow++;
            if (!vsync_n)      vsLow++;
            if (frame_tick)    tickCnt++;
            if (blank_n)       blankHi++;
            if (vga_r == 4'hA) redHit++;
        end
    endtask

    // Monitor: compare whenever a queued response is due, just after each edge
    initial begin
        forever begin
            @(posedge pixel_clck);
            #1;
            if (expQueue.size() > 0) checkOutput();
        end
    end

    // Compare one accumulated count against its required value
    task automatic checkCount(input string name, input int got, input int req);
        total++;
        if (got != req) begin
            bad++;
            $display("[TB] FAIL %s got=%0d required=%0d", name, got, req);
        end
    endtask

    // Directed sequence: reset, two counted frames, mid-frame reset, colour variety
    initial begin
        logic [3:0] colTab [4];
        int guard;
        colTab[0] = 4'h1; colTab[1] = 4'h7; colTab[2] = 4'hC; colTab[3] = 4'hF;

        $display("[TB] start");
        repeat (3) applyStimulus(1'b1, 4'hA, 4'h5, 4'h3, 1'b0);

        // Two whole frames counted from the raster origin
        for (int i = 0; i < 2 * 800 * 13; i++) applyStimulus(1'b0, 4'hA, 4'h5, 4'h3, 1'b1);

        // Run to x=300, y=3, then hold reset for three cycles
        guard = 0;
        while (!(modelH == 300 && modelV == 3) && guard < 20000) begin
            applyStimulus(1'b0, 4'h6, 4'h9, 4'h2, 1'b0);
            guard++;
        end
        checkCount("reach_300_3", guard < 20000 ? 1 : 0, 1);
        repeat (3) applyStimulus(1'b1, 4'h6, 4'h9, 4'h2, 1'b0);

        // After release, colour values change every cycle
        for (int i = 0; i < 1700; i++)
            applyStimulus(1'b0, colTab[i % 4], colTab[(i + 1) % 4], colTab[(i + 2) % 4], 1'b0);

        repeat (3) @(posedge pixel_clck);
        #2;
        checkCount("queue_drained", expQueue.size(), 0);
        checkCount("hsync_low_cycles", hsLow, 2 * 13 * 96);
        checkCount("vsync_low_cycles", vsLow, 2 * 2 * 800);
        checkCount("frame_ticks", tickCnt, 2);
        checkCount("blank_high_cycles", blankHi, 2 * 6 * 640);
`ifdef VGA_TEST_PATTERN_EN
        checkCount("red_a_cycles", redHit, 0);
`else
        checkCount("red_a_cycles", redHit, 2 * 6 * 640);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
